// File: rtl/adder64_arbiter.sv
// Round-robin scheduler that time-shares one external combinational adder64
// among NUM_REQ requesters and returns each sum with its owner's ID.
module adder64_arbiter #(
    parameter int WIDTH   = 64,
    parameter int NUM_REQ = 2,
    localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    input  logic [WIDTH-1:0]         add_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic [IDW-1:0]           rsp_id,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   gnt_id;
    logic [IDW-1:0]   grant;
    logic             any_valid;
    logic             load_req;
    logic             capture;
    logic             release_rsp;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    function automatic logic [IDW-1:0] rr_pick(
        input logic [NUM_REQ-1:0] valid,
        input logic [IDW-1:0]     ptr
    );
        logic [IDW-1:0] pick;
        logic [IDW:0]   idx;
        pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NUM_REQ))
                idx = idx - (IDW+1)'(NUM_REQ);
            if (valid[idx[IDW-1:0]])
                pick = idx[IDW-1:0];
        end
        return pick;
    endfunction

    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] id);
        if (id == IDW'(NUM_REQ - 1))
            return '0;
        return id + 1'b1;
    endfunction

    assign any_valid = |req_valid;
    assign grant     = rr_pick(req_valid, rr_ptr);

    // Grant is only offered in IDLE, and never while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (reset_n && state == IDLE && any_valid)
            req_ready = NUM_REQ'(1) << grant;
    end

    assign add_a = op_a;
    assign add_b = op_b;
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        load_req    = 1'b0;
        capture     = 1'b0;
        release_rsp = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    load_req   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                capture    = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    release_rsp = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr    <= '0;
            gnt_id    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            rsp_sum   <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
        end else begin
            if (load_req) begin
                op_a   <= req_a[grant*WIDTH +: WIDTH];
                op_b   <= req_b[grant*WIDTH +: WIDTH];
                gnt_id <= grant;
            end
            // Carry-out of the shared adder is intentionally dropped.
            if (capture) begin
                rsp_sum   <= add_result;
                rsp_id    <= gnt_id;
                rsp_valid <= 1'b1;
            end
            if (release_rsp) begin
                rsp_valid <= 1'b0;
                rr_ptr    <= next_ptr(gnt_id);
            end
        end
    end

endmodule

// File: tb/tb_adder64_arbiter.sv
// Directed bench for adder64_arbiter with a behavioural adder on the shared port.
module tb_adder64_arbiter;

    localparam int WIDTH   = 64;
    localparam int NUM_REQ = 2;
    localparam int IDW     = 1;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]         add_a;
    logic [WIDTH-1:0]         add_b;
    logic [WIDTH-1:0]         add_result;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [WIDTH-1:0]         rsp_sum;
    logic [IDW-1:0]           rsp_id;
    logic                     busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign add_result = add_a + add_b;

    adder64_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .add_a(add_a), .add_b(add_b), .add_result(add_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
        .rsp_id(rsp_id), .busy(busy)
    );

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Runs one transaction with rsp_ready=1; entered and left on a negedge in IDLE.
    task automatic run_one(input int id, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] exp_sum, input string tag);
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
        req_valid = 2'(1 << id);
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'(1 << id)) begin
            errors++; $display("FAIL %s grant: got %b expected %b", tag, req_ready, 2'(1 << id));
        end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || req_ready !== 2'b00 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL %s issue ctl: busy=%b req_ready=%b rsp_valid=%b expected 1 00 0",
                               tag, busy, req_ready, rsp_valid);
        end
        checks++;
        if (add_a !== a || add_b !== b) begin
            errors++; $display("FAIL %s operands: got %h %h expected %h %h", tag, add_a, add_b, a, b);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_sum !== exp_sum || rsp_id !== IDW'(id)) begin
            errors++; $display("FAIL %s resp: valid=%b sum=%h id=%0d expected 1 %h %0d",
                               tag, rsp_valid, rsp_sum, rsp_id, exp_sum, id);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL %s idle: valid=%b busy=%b expected 0 0", tag, rsp_valid, busy);
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        rsp_ready = 1'b0;
        req_a     = {64'd80, 64'd40};
        req_b     = {64'd7, 64'd9};
        req_valid = 2'b11;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b00 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset ctl: req_ready=%b rsp_valid=%b busy=%b expected 00 0 0",
                               req_ready, rsp_valid, busy);
        end
        checks++;
        if (add_a !== 64'd0 || add_b !== 64'd0 || rsp_sum !== 64'd0 || rsp_id !== 1'b0) begin
            errors++; $display("FAIL reset data: add_a=%h add_b=%h sum=%h id=%0d expected zeros",
                               add_a, add_b, rsp_sum, rsp_id);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL reset first grant: got %b expected 01", req_ready);
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_single();
        run_one(0, 64'd10, 64'd20, 64'd30, "single");
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_gnt;
        logic [63:0] exp_sum;
        do_reset();
        req_a     = {64'd5, 64'd40};
        req_b     = {64'd7, 64'd80};
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_sum = (i % 2 == 0) ? 64'd120 : 64'd12;
            #1;
            checks++;
            if (req_ready !== exp_gnt) begin
                errors++; $display("FAIL rr grant %0d: got %b expected %b", i, req_ready, exp_gnt);
            end
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_sum !== exp_sum || rsp_id !== IDW'(i % 2)) begin
                errors++; $display("FAIL rr resp %0d: valid=%b sum=%0d id=%0d expected 1 %0d %0d",
                                   i, rsp_valid, rsp_sum, rsp_id, exp_sum, i % 2);
            end
            @(negedge clk);
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        req_a[WIDTH-1:0] = 64'd100;
        req_b[WIDTH-1:0] = 64'd23;
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL bp grant: got %b expected 01", req_ready);
        end
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_sum !== 64'd123 || rsp_id !== 1'b0 || req_ready !== 2'b00) begin
                errors++; $display("FAIL bp hold %0d: valid=%b sum=%0d id=%0d req_ready=%b expected 1 123 0 00",
                                   k, rsp_valid, rsp_sum, rsp_id, req_ready);
            end
            if (k < 4) @(negedge clk);
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL bp release: valid=%b busy=%b expected 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_wrap();
        run_one(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, "wrap_ones");
        run_one(0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, "wrap_msb");
    endtask

    task automatic test_reset_in_issue();
        req_a[WIDTH +: WIDTH] = 64'd3;
        req_b[WIDTH +: WIDTH] = 64'd4;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++; $display("FAIL rst_issue grant: got %b expected 10", req_ready);
        end
        @(posedge clk); #1;
        req_valid = '0;
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || add_a !== 64'd0 || req_ready !== 2'b00) begin
            errors++; $display("FAIL rst_issue async: busy=%b valid=%b add_a=%h req_ready=%b expected 0 0 0 00",
                               busy, rsp_valid, add_a, req_ready);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL rst_issue no resp %0d: valid=%b busy=%b expected 0 0",
                                   k, rsp_valid, busy);
            end
        end
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL rst_issue ptr: got %b expected 01", req_ready);
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_reset_in_issue();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
